// File: rtl/cordic_seq_sincos.sv
// Iterative CORDIC rotator: one micro-rotation per clock, producing cos/sin of a Q2.WIDTH angle
// behind a valid/ready handshake, with the residual angle exposed for convergence checks.
module cordic_seq_sincos #(
    parameter int WIDTH = 24,
    parameter int ITERS = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH+1:0] angle,
    input  logic [4:0]       iters,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] cos_out,
    output logic [WIDTH+1:0] sin_out,
    output logic [WIDTH+1:0] theta_res
);

    localparam int             D      = WIDTH + 2;
    localparam int             SHIFT  = 24 - WIDTH;
    localparam logic [25:0]    K_Q24  = 26'h09B74EE;
    localparam logic [D-1:0]   K_INIT = D'(K_Q24 >> SHIFT);
    localparam logic [4:0]     MAX_N  = 5'(ITERS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // atan(2^-i) in Q2.24; from i=8 on the cubic term is below half an LSB.
    function automatic logic [25:0] atan_q24(input logic [4:0] idx);
        logic [25:0] r;
        case (idx)
            5'd0:    r = 26'h0C90FDB;
            5'd1:    r = 26'h076B19C;
            5'd2:    r = 26'h03EB6EC;
            5'd3:    r = 26'h01FD5BB;
            5'd4:    r = 26'h00FFAAE;
            5'd5:    r = 26'h007FF55;
            5'd6:    r = 26'h003FFEB;
            5'd7:    r = 26'h001FFFD;
            default: r = (idx <= 5'd24) ? (26'd1 << (5'd24 - idx)) : '0;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic signed [D-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [D-1:0]   x_rot, y_rot, z_rot, atan_i;
    logic [4:0]            i_q, i_d, n_q, n_d, n_req;
    logic [D-1:0]          cos_q, cos_d, sin_q, sin_d, res_q, res_d;

    always_comb begin
        atan_i = $signed(D'(atan_q24(i_q) >> SHIFT));
        if (!z_q[D-1]) begin
            x_rot = x_q - (y_q >>> i_q);
            y_rot = y_q + (x_q >>> i_q);
            z_rot = z_q - atan_i;
        end else begin
            x_rot = x_q + (y_q >>> i_q);
            y_rot = y_q - (x_q >>> i_q);
            z_rot = z_q + atan_i;
        end
        n_req = (iters == 5'd0 || iters > MAX_N) ? MAX_N : iters;

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        n_d     = n_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = $signed(K_INIT);
                    y_d     = '0;
                    z_d     = $signed(angle);
                    i_d     = '0;
                    n_d     = n_req;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                i_d = i_q + 5'd1;
                if (i_q == n_q - 5'd1) begin
                    cos_d   = x_rot;
                    sin_d   = y_rot;
                    res_d   = z_rot;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            n_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            n_q     <= n_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign theta_res = res_q;

endmodule

// File: tb/tb_cordic_seq_sincos.sv
// Scoreboard bench for cordic_seq_sincos: driver pushes reference results computed from real-valued
// atan tables and plain integer rotations; a negedge monitor pops and compares every presented result.
module tb_cordic_seq_sincos;

    localparam real SCALE = 16777216.0;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [25:0] angle, cos_out, sin_out, theta_res;
    logic [4:0]  iters;

    cordic_seq_sincos #(.WIDTH(24), .ITERS(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .angle(angle), .iters(iters), .out_valid(out_valid), .out_ready(out_ready),
        .cos_out(cos_out), .sin_out(sin_out), .theta_res(theta_res)
    );

    typedef struct {
        longint c, s, r;
        int     n, acc;
        bit     trig;
        real    theta;
        int     res_tol;
    } exp_t;

    exp_t   sb[$];
    longint atan_tab[32];
    int     checks = 0, errors = 0, cyc = 0, nacc = 0, nres = 0;
    bit     have_cur = 0, rdy_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint rnd(real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    endfunction

    function automatic longint wrap26(longint v);
        return (v <<< 38) >>> 38;
    endfunction

    function automatic void cordic_model(input longint ang, input int n,
                                         output longint xo, output longint yo, output longint zo);
        longint x, y, z, xn, yn, zn;
        x = 64'h09B74EE; y = 0; z = ang;
        for (int i = 0; i < n; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); yn = y + (x >>> i); zn = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i); yn = y - (x >>> i); zn = z + atan_tab[i];
            end
            x = wrap26(xn); y = wrap26(yn); z = wrap26(zn);
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_tol(string name, longint act, longint req, longint tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d (t=%0t)", name, act, req, tol, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [25:0] rand_angle();
        int v;
        v = int'($urandom_range(0, 52707178)) - 26353589;
        return 26'(v);
    endfunction

    // Holds in_valid until the DUT is idle; the expectation is pushed on the accepting cycle.
    task automatic send(input logic [25:0] a, input logic [4:0] it, input bit trig, input int res_tol);
        bit   accepted;
        int   waited;
        exp_t e;
        longint ang;
        accepted = 0; waited = 0;
        in_valid = 1'b1; angle = a; iters = it;
        while (!accepted) begin
            @(negedge clk);
            if (in_ready) begin
                ang = wrap26(longint'(a));
                e.n = (it == 5'd0 || it > 5'd24) ? 24 : int'(it);
                cordic_model(ang, e.n, e.c, e.s, e.r);
                e.acc = cyc + 1; e.trig = trig; e.res_tol = res_tol;
                e.theta = real'(ang) / SCALE;
                sb.push_back(e);
                nacc++;
                accepted = 1;
            end
            tick();
            waited++;
            if (!accepted && waited > 2000) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        angle = 26'($urandom);
        iters = 5'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (sb.size() == 0 && !out_valid) return;
            tick();
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                have_cur = 0;
                continue;
            end
            if (out_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        exp_t cur;
                        cur = sb.pop_front();
                        have_cur = 1;
                        nres++;
                        chk("latency", longint'(cyc - cur.acc), longint'(cur.n));
                        if (cur.trig) begin
                            chk_tol("cos_vs_real", longint'($signed(cos_out)), rnd($cos(cur.theta) * SCALE), 24);
                            chk_tol("sin_vs_real", longint'($signed(sin_out)), rnd($sin(cur.theta) * SCALE), 24);
                        end
                        if (cur.res_tol >= 0)
                            chk_tol("theta_res_converged", longint'($signed(theta_res)), 0, longint'(cur.res_tol));
                        sb.push_front(cur);
                    end
                end
                if (have_cur) begin
                    chk("cos_out", longint'($signed(cos_out)), sb[0].c);
                    chk("sin_out", longint'($signed(sin_out)), sb[0].s);
                    chk("theta_res", longint'($signed(theta_res)), sb[0].r);
                    if (out_ready) begin
                        have_cur = 0;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dropped, k;
        for (int i = 0; i < 32; i++)
            atan_tab[i] = rnd($atan($pow(2.0, -real'(i))) * SCALE);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; angle = '0; iters = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_outputs", longint'({cos_out, sin_out, theta_res}), 0);
        tick();

        send(26'h0000000, 5'd24, 1, -1);
        send(26'h0C90FDB, 5'd24, 1, 2);
        send(26'h37A7D6A, 5'd24, 1, -1);
        send(26'h0C90FDB, 5'd4, 0, -1);
        send(26'h0860A92, 5'd0, 1, -1);
        send(26'h3B7E151, 5'd31, 1, -1);
        drain();

        out_ready = 1'b0;
        send(rand_angle(), 5'd24, 1, -1);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("stall_reached_done", longint'(out_valid), 1);
        for (int j = 0; j < 6; j++) begin
            tick();
            in_valid = j[0];
            angle = rand_angle();
            @(negedge clk);
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_out_valid", longint'(out_valid), 1);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("release_in_ready", longint'(in_ready), 1);
        chk("release_out_valid", longint'(out_valid), 0);
        tick();

        send(rand_angle(), 5'd24, 1, -1);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dropped = sb.size();
        sb.delete();
        nacc -= dropped;
        @(negedge clk);
        chk("midrun_reset_in_ready", longint'(in_ready), 1);
        chk("midrun_reset_out_valid", longint'(out_valid), 0);
        chk("midrun_reset_outputs", longint'({cos_out, sin_out, theta_res}), 0);
        tick();
        send(26'h0C90FDB, 5'd24, 1, 2);
        drain();

        rdy_rand = 1;
        for (int t = 0; t < 40; t++) begin
            logic [4:0] it;
            case ($urandom_range(0, 5))
                0:       it = 5'd0;
                1:       it = 5'd31;
                default: it = 5'($urandom_range(1, 30));
            endcase
            send(rand_angle(), it, 0, -1);
        end
        drain();
        rdy_rand = 0;
        out_ready = 1'b1;

        chk("pending_results", longint'(sb.size()), 0);
        chk("result_count", longint'(nres), longint'(nacc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
